// File: rtl/operand_fetch_unit_if.sv
// Operand fetch bus: register-file read/write ports, operand latch controls,
// and the three operand outputs that feed the ALU.
//   master : control unit / write-back side (drives addresses, data, strobes)
//   slave  : operand_fetch_unit (drives InputDataA/B, ImmediateDataB)
interface operand_fetch_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
);
  logic [ADDR_W-1:0] ReadRegA;
  logic [ADDR_W-1:0] ReadRegB;
  logic              LatchEn;
  logic              RegWre;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [IMM_W-1:0]  Imm16;
  logic              ExtSel;
  logic [DATA_W-1:0] InputDataA;
  logic [DATA_W-1:0] InputDataB;
  logic [DATA_W-1:0] ImmediateDataB;

  modport master (
    output ReadRegA, ReadRegB, LatchEn, RegWre, WriteReg, WriteData, Imm16, ExtSel,
    input  InputDataA, InputDataB, ImmediateDataB
  );

  modport slave (
    input  ReadRegA, ReadRegB, LatchEn, RegWre, WriteReg, WriteData, Imm16, ExtSel,
    output InputDataA, InputDataB, ImmediateDataB
  );
endinterface

// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: GPR file plus the A/B/immediate operand latches that sit
// in front of the ALU. Operands captured on a LatchEn edge are valid at the
// ALU in the following (EXE) cycle.
//   CLK    : single clock, rising edge
//   RST_n  : asynchronous active-low reset; clears GPRs and all three outputs
//   bus    : operand_fetch_unit_if.slave (read addresses, write-back port,
//            immediate + ExtSel, latched operand outputs)
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge write-back
// data into the operand latches (write-through). Without it the latch sees
// the pre-write register value.
module operand_fetch_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
) (
  input logic                 CLK,
  input logic                 RST_n,
  operand_fetch_unit_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr [NREG];
  logic [DATA_W-1:0] rdA, rdB, immExt;

  // Read with R0 hard-wired to zero; forwarding (when enabled) never applies
  // to R0 because a write to R0 is dropped.
  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (addr != '0) begin
      val = gpr[addr];
`ifdef REGFILE_BYPASS_EN
      if (bus.RegWre && (bus.WriteReg == addr)) val = bus.WriteData;
`endif
    end
    return val;
  endfunction

  always_comb begin
    rdA    = readPort(bus.ReadRegA);
    rdB    = readPort(bus.ReadRegB);
    immExt = {{(DATA_W-IMM_W){bus.ExtSel & bus.Imm16[IMM_W-1]}}, bus.Imm16};
  end

  // Register file; entry 0 stays at its reset value of zero.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (bus.RegWre && (bus.WriteReg != '0)) begin
      gpr[bus.WriteReg] <= bus.WriteData;
    end
  end

  // Operand latches; hold when LatchEn is low.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      bus.InputDataA     <= '0;
      bus.InputDataB     <= '0;
      bus.ImmediateDataB <= '0;
    end else if (bus.LatchEn) begin
      bus.InputDataA     <= rdA;
      bus.InputDataB     <= rdB;
      bus.ImmediateDataB <= immExt;
    end
  end
endmodule

// File: tb/tb_operand_fetch_unit.sv
module tb_operand_fetch_unit;
  logic CLK = 1'b0;
  logic RST_n;
  int   total = 0;
  int   bad   = 0;

  // Reference state: plain array of register contents plus expected outputs.
  logic [31:0] mdl [32];
  logic [31:0] expA, expB, expI;

  operand_fetch_unit_if bus ();

  operand_fetch_unit dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] extImm(input logic [15:0] imm, input logic ext);
    logic [31:0] v;
    v = 32'(imm);
    if (ext && imm[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] refRead(input logic [4:0] a, input logic we,
                                         input logic [4:0] wr, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wr == a) return wd;
`endif
    return mdl[a];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    expA = 32'd0; expB = 32'd0; expI = 32'd0;
  endtask

  task automatic checkOuts(input string tag);
    chk({tag, ".A"}, bus.InputDataA, expA);
    chk({tag, ".B"}, bus.InputDataB, expB);
    chk({tag, ".I"}, bus.ImmediateDataB, expI);
  endtask

  // Drive one cycle (called right after a falling edge), update the model for
  // the rising edge, and compare all outputs shortly after it.
  task automatic step(input string tag, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic le, input logic [4:0] ra,
                      input logic [4:0] rb, input logic [15:0] imm, input logic ext);
    bus.RegWre = we; bus.WriteReg = wr; bus.WriteData = wd;
    bus.LatchEn = le; bus.ReadRegA = ra; bus.ReadRegB = rb;
    bus.Imm16 = imm; bus.ExtSel = ext;
    @(posedge CLK);
    if (le) begin
      expA = refRead(ra, we, wr, wd);
      expB = refRead(rb, we, wr, wd);
      expI = extImm(imm, ext);
    end
    if (we && wr != 5'd0) mdl[wr] = wd;
    #1;
    checkOuts(tag);
    @(negedge CLK);
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    step("wr", 1'b1, r, d, 1'b0, 5'd0, 5'd0, 16'h0, 1'b0);
  endtask

  task automatic lat(input string tag, input logic [4:0] ra, input logic [4:0] rb,
                     input logic [15:0] imm, input logic ext);
    step(tag, 1'b0, 5'd0, 32'd0, 1'b1, ra, rb, imm, ext);
  endtask

  initial begin
    RST_n = 1'b0;
    bus.RegWre = 1'b0; bus.WriteReg = '0; bus.WriteData = '0;
    bus.LatchEn = 1'b0; bus.ReadRegA = '0; bus.ReadRegB = '0;
    bus.Imm16 = '0; bus.ExtSel = 1'b0;
    clearModel();
    #3;
    checkOuts("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST_n = 1'b1;

    // Reset during activity
    wr(5'd5, 32'h1234);
    lat("r5", 5'd5, 5'd5, 16'hFFFF, 1'b1);
    #2 RST_n = 1'b0;
    #1;
    clearModel();
    checkOuts("midrst");
    #1 RST_n = 1'b1;
    @(negedge CLK);
    lat("r5post", 5'd5, 5'd0, 16'h0, 1'b0);

    // Write/read
    wr(5'd3, 32'hDEADBEEF);
    wr(5'd7, 32'h0000_0010);
    lat("rw", 5'd3, 5'd7, 16'h0001, 1'b0);
    chk("rwA", bus.InputDataA, 32'hDEADBEEF);
    chk("rwB", bus.InputDataB, 32'h0000_0010);

    // Register 0, plain and with same-edge write to R0
    wr(5'd0, 32'hFFFF_FFFF);
    lat("r0", 5'd0, 5'd0, 16'h0, 1'b0);
    step("r0same", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 16'h0, 1'b0);
    chk("r0A", bus.InputDataA, 32'd0);

    // Extension
    lat("sext", 5'd3, 5'd3, 16'h8001, 1'b1);
    chk("sextI", bus.ImmediateDataB, 32'hFFFF_8001);
    lat("zext", 5'd3, 5'd3, 16'h8001, 1'b0);
    chk("zextI", bus.ImmediateDataB, 32'h0000_8001);

    // Hold
    wr(5'd6, 32'h5);
    lat("hold0", 5'd6, 5'd3, 16'h7FFF, 1'b1);
    for (int i = 0; i < 3; i++) wr(5'd6, 32'h9);
    chk("holdA", bus.InputDataA, 32'h5);
    lat("hold1", 5'd6, 5'd3, 16'h0, 1'b0);
    chk("holdA2", bus.InputDataA, 32'h9);

    // Collision
    wr(5'd4, 32'h1);
    step("coll", 1'b1, 5'd4, 32'h2, 1'b1, 5'd4, 5'd3, 16'h0, 1'b0);
`ifdef REGFILE_BYPASS_EN
    chk("collA", bus.InputDataA, 32'h2);
`else
    chk("collA", bus.InputDataA, 32'h1);
`endif
    lat("collnext", 5'd4, 5'd4, 16'h0, 1'b0);

    // Random traffic over a narrow address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      step("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
